// File: rtl/control_sequencer.sv
// Hardwired control unit for the datapath: runs fetch T0..T2, then the execute
// steps for IR[31:27], and stops in HALT on a halt opcode or a Stop request.
module control_sequencer #(
    parameter logic [4:0] ADD_OP = 5'b00011
) (
    input  logic        Clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        CON_FF,
    input  logic        Stop,
    output logic        Run,
    output logic [4:0]  alu_op,
    output logic        Read,
    output logic        Write,
    output logic        IncPC,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        HIin,
    output logic        LOin,
    output logic        Yin,
    output logic        Zin,
    output logic        PCin,
    output logic        IRin,
    output logic        MARin,
    output logic        MDRin,
    output logic        Inportin,
    output logic        Outportin,
    output logic        CONin,
    output logic        HIout,
    output logic        LOout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        PCout,
    output logic        MDRout,
    output logic        Inportout,
    output logic        Cout
);

    typedef enum logic [3:0] {
        ST_RESET, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
    } state_t;

    typedef enum logic [3:0] {
        K_NOP, K_ALU, K_IMM, K_MULDIV, K_NEGNOT, K_LD, K_LDI, K_ST,
        K_BR, K_JR, K_IN, K_OUT, K_MFHI, K_MFLO, K_HALT
    } kind_t;

    state_t      state_q, state_d;
    kind_t       kind;
    logic [4:0]  opcode;
    logic [2:0]  step;
    logic [2:0]  last_step;
    logic        unused_ir;

    assign opcode    = IR[31:27];
    assign unused_ir = ^IR[26:0];

    always_ff @(posedge Clock or posedge clear) begin
        if (clear) state_q <= ST_RESET;
        else       state_q <= state_d;
    end

    always_comb begin
        kind = K_NOP;
        case (opcode)
            5'b00011, 5'b00100, 5'b00101, 5'b00110,
            5'b00111, 5'b01000, 5'b01001, 5'b01010: kind = K_ALU;
            5'b01011, 5'b01100, 5'b01101:           kind = K_IMM;
            5'b01110, 5'b01111:                     kind = K_MULDIV;
            5'b10000, 5'b10001:                     kind = K_NEGNOT;
            5'b00000:                               kind = K_LD;
            5'b00001:                               kind = K_LDI;
            5'b00010:                               kind = K_ST;
            5'b10010:                               kind = K_BR;
            5'b10011:                               kind = K_JR;
            5'b10101:                               kind = K_IN;
            5'b10110:                               kind = K_OUT;
            5'b10111:                               kind = K_MFHI;
            5'b11000:                               kind = K_MFLO;
            5'b11010:                               kind = K_HALT;
            default:                                kind = K_NOP;
        endcase
    end

    // Index of the final step of the current instruction; fetch is steps 0..2.
    always_comb begin
        last_step = 3'd2;
        case (kind)
            K_JR, K_IN, K_OUT, K_MFHI, K_MFLO: last_step = 3'd3;
            K_NEGNOT:                          last_step = 3'd4;
            K_ALU, K_IMM, K_LDI:               last_step = 3'd5;
            K_MULDIV, K_BR:                    last_step = 3'd6;
            K_LD, K_ST:                        last_step = 3'd7;
            default:                           last_step = 3'd2;
        endcase
    end

    always_comb begin
        step = 3'd0;
        case (state_q)
            ST_T1:   step = 3'd1;
            ST_T2:   step = 3'd2;
            ST_T3:   step = 3'd3;
            ST_T4:   step = 3'd4;
            ST_T5:   step = 3'd5;
            ST_T6:   step = 3'd6;
            ST_T7:   step = 3'd7;
            default: step = 3'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET: state_d = Stop ? ST_HALT : ST_T0;
            ST_HALT:  state_d = ST_HALT;
            default: begin
                if (step == last_step) begin
                    state_d = (kind == K_HALT || Stop) ? ST_HALT : ST_T0;
                end else begin
                    case (state_q)
                        ST_T0:   state_d = ST_T1;
                        ST_T1:   state_d = ST_T2;
                        ST_T2:   state_d = ST_T3;
                        ST_T3:   state_d = ST_T4;
                        ST_T4:   state_d = ST_T5;
                        ST_T5:   state_d = ST_T6;
                        ST_T6:   state_d = ST_T7;
                        default: state_d = ST_T0;
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        Run       = (state_q != ST_HALT);
        alu_op    = 5'd0;
        Read      = 1'b0;
        Write     = 1'b0;
        IncPC     = 1'b0;
        Gra       = 1'b0;
        Grb       = 1'b0;
        Grc       = 1'b0;
        Rin       = 1'b0;
        Rout      = 1'b0;
        BAout     = 1'b0;
        HIin      = 1'b0;
        LOin      = 1'b0;
        Yin       = 1'b0;
        Zin       = 1'b0;
        PCin      = 1'b0;
        IRin      = 1'b0;
        MARin     = 1'b0;
        MDRin     = 1'b0;
        Inportin  = 1'b0;
        Outportin = 1'b0;
        CONin     = 1'b0;
        HIout     = 1'b0;
        LOout     = 1'b0;
        Zhighout  = 1'b0;
        Zlowout   = 1'b0;
        PCout     = 1'b0;
        MDRout    = 1'b0;
        Inportout = 1'b0;
        Cout      = 1'b0;
        case (state_q)
            ST_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
            ST_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            ST_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            ST_T3: begin
                case (kind)
                    K_ALU, K_IMM:     begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    K_MULDIV:         begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    K_NEGNOT:         begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode; end
                    K_LD, K_LDI, K_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                    K_BR:             begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                    K_JR:             begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                    K_IN:             begin Inportout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    K_OUT:            begin Gra = 1'b1; Rout = 1'b1; Outportin = 1'b1; end
                    K_MFHI:           begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    K_MFLO:           begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    default: ;
                endcase
            end
            ST_T4: begin
                case (kind)
                    K_ALU:            begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode; end
                    K_IMM:            begin Cout = 1'b1; Zin = 1'b1; alu_op = opcode; end
                    K_MULDIV:         begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode; end
                    K_NEGNOT:         begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    K_LD, K_LDI, K_ST: begin Cout = 1'b1; Zin = 1'b1; alu_op = ADD_OP; end
                    K_BR:             begin PCout = 1'b1; Yin = 1'b1; end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (kind)
                    K_ALU, K_IMM, K_LDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    K_MULDIV:            begin Zlowout = 1'b1; LOin = 1'b1; end
                    K_LD, K_ST:          begin Zlowout = 1'b1; MARin = 1'b1; end
                    K_BR:                begin Cout = 1'b1; Zin = 1'b1; alu_op = ADD_OP; end
                    default: ;
                endcase
            end
            ST_T6: begin
                case (kind)
                    K_MULDIV: begin Zhighout = 1'b1; HIin = 1'b1; end
                    K_LD:     begin Read = 1'b1; MDRin = 1'b1; end
                    K_ST:     begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                    // Untaken branch still burns this cycle with no strobes.
                    K_BR:     begin Zlowout = CON_FF; PCin = CON_FF; end
                    default: ;
                endcase
            end
            ST_T7: begin
                case (kind)
                    K_LD:    begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    K_ST:    Write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: a table-driven model queues the
// expected per-cycle control word, and a negedge monitor pops and compares.
module tb_control_sequencer;

    typedef logic [33:0] vec_t;

    localparam logic [27:0] M_READ = 28'd1 << 0,  M_WRITE = 28'd1 << 1,  M_INCPC = 28'd1 << 2;
    localparam logic [27:0] M_GRA = 28'd1 << 3,   M_GRB = 28'd1 << 4,    M_GRC = 28'd1 << 5;
    localparam logic [27:0] M_RIN = 28'd1 << 6,   M_ROUT = 28'd1 << 7,   M_BAOUT = 28'd1 << 8;
    localparam logic [27:0] M_HIIN = 28'd1 << 9,  M_LOIN = 28'd1 << 10,  M_YIN = 28'd1 << 11;
    localparam logic [27:0] M_ZIN = 28'd1 << 12,  M_PCIN = 28'd1 << 13,  M_IRIN = 28'd1 << 14;
    localparam logic [27:0] M_MARIN = 28'd1 << 15, M_MDRIN = 28'd1 << 16, M_INPIN = 28'd1 << 17;
    localparam logic [27:0] M_OUTPIN = 28'd1 << 18, M_CONIN = 28'd1 << 19, M_HIOUT = 28'd1 << 20;
    localparam logic [27:0] M_LOOUT = 28'd1 << 21, M_ZHOUT = 28'd1 << 22, M_ZLOUT = 28'd1 << 23;
    localparam logic [27:0] M_PCOUT = 28'd1 << 24, M_MDROUT = 28'd1 << 25, M_INPOUT = 28'd1 << 26;
    localparam logic [27:0] M_COUT = 28'd1 << 27;
    localparam logic [4:0]  ADD = 5'b00011;
    localparam vec_t V_RESET = {1'b1, 5'd0, 28'd0};
    localparam vec_t V_HALT  = {1'b0, 5'd0, 28'd0};

    logic        Clock = 1'b0;
    logic        clear = 1'b1;
    logic [31:0] IR = 32'd0;
    logic        CON_FF = 1'b0;
    logic        Stop = 1'b0;
    logic        Run, Read, Write, IncPC, Gra, Grb, Grc, Rin, Rout, BAout;
    logic        HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin, Inportin, Outportin, CONin;
    logic        HIout, LOout, Zhighout, Zlowout, PCout, MDRout, Inportout, Cout;
    logic [4:0]  alu_op;

    int   compared = 0;
    int   mismatched = 0;
    vec_t exp_q[$];
    vec_t seq[$];
    bit   seq_halts;

    always #5 Clock = ~Clock;

    control_sequencer dut (
        .Clock(Clock), .clear(clear), .IR(IR), .CON_FF(CON_FF), .Stop(Stop), .Run(Run),
        .alu_op(alu_op), .Read(Read), .Write(Write), .IncPC(IncPC), .Gra(Gra), .Grb(Grb),
        .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .HIin(HIin), .LOin(LOin),
        .Yin(Yin), .Zin(Zin), .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin),
        .Inportin(Inportin), .Outportin(Outportin), .CONin(CONin), .HIout(HIout),
        .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout), .PCout(PCout),
        .MDRout(MDRout), .Inportout(Inportout), .Cout(Cout)
    );

    function automatic vec_t v(input logic [4:0] alu, input logic [27:0] m);
        return {1'b1, alu, m};
    endfunction

    // Reference: list of control words, one per cycle, for one instruction.
    task automatic model(input logic [4:0] op, input logic con);
        seq = {};
        seq_halts = 1'b0;
        seq.push_back(v(0, M_PCOUT | M_MARIN | M_INCPC | M_ZIN));
        seq.push_back(v(0, M_ZLOUT | M_PCIN | M_READ | M_MDRIN));
        seq.push_back(v(0, M_MDROUT | M_IRIN));
        if (op >= 5'd3 && op <= 5'd13) begin
            seq.push_back(v(0, M_GRB | M_ROUT | M_YIN));
            seq.push_back(op <= 5'd10 ? v(op, M_GRC | M_ROUT | M_ZIN) : v(op, M_COUT | M_ZIN));
            seq.push_back(v(0, M_ZLOUT | M_GRA | M_RIN));
        end else if (op == 5'd14 || op == 5'd15) begin
            seq.push_back(v(0, M_GRA | M_ROUT | M_YIN));
            seq.push_back(v(op, M_GRB | M_ROUT | M_ZIN));
            seq.push_back(v(0, M_ZLOUT | M_LOIN));
            seq.push_back(v(0, M_ZHOUT | M_HIIN));
        end else if (op == 5'd16 || op == 5'd17) begin
            seq.push_back(v(op, M_GRB | M_ROUT | M_ZIN));
            seq.push_back(v(0, M_ZLOUT | M_GRA | M_RIN));
        end else if (op <= 5'd2) begin
            seq.push_back(v(0, M_GRB | M_BAOUT | M_YIN));
            seq.push_back(v(ADD, M_COUT | M_ZIN));
            if (op == 5'd1) seq.push_back(v(0, M_ZLOUT | M_GRA | M_RIN));
            else begin
                seq.push_back(v(0, M_ZLOUT | M_MARIN));
                if (op == 5'd0) begin
                    seq.push_back(v(0, M_READ | M_MDRIN));
                    seq.push_back(v(0, M_MDROUT | M_GRA | M_RIN));
                end else begin
                    seq.push_back(v(0, M_GRA | M_ROUT | M_MDRIN));
                    seq.push_back(v(0, M_WRITE));
                end
            end
        end else begin
            case (op)
                5'd18: begin
                    seq.push_back(v(0, M_GRA | M_ROUT | M_CONIN));
                    seq.push_back(v(0, M_PCOUT | M_YIN));
                    seq.push_back(v(ADD, M_COUT | M_ZIN));
                    seq.push_back(con ? v(0, M_ZLOUT | M_PCIN) : v(0, 0));
                end
                5'd19: seq.push_back(v(0, M_GRA | M_ROUT | M_PCIN));
                5'd21: seq.push_back(v(0, M_INPOUT | M_GRA | M_RIN));
                5'd22: seq.push_back(v(0, M_GRA | M_ROUT | M_OUTPIN));
                5'd23: seq.push_back(v(0, M_HIOUT | M_GRA | M_RIN));
                5'd24: seq.push_back(v(0, M_LOOUT | M_GRA | M_RIN));
                5'd26: seq_halts = 1'b1;
                default: ;
            endcase
        end
    endtask

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic do_clear;
        tick(); clear = 1'b1; Stop = 1'b0; exp_q.push_back(V_RESET);
        tick(); exp_q.push_back(V_RESET);
        tick(); clear = 1'b0; exp_q.push_back(V_RESET);
    endtask

    task automatic halt_cycles(input int n);
        repeat (n) begin tick(); exp_q.push_back(V_HALT); end
    endtask

    task automatic run_instr(input logic [31:0] ir, input logic con, input int stop_cyc,
                             input int abort_cyc, output bit halted);
        model(ir[31:27], con);
        halted = 1'b0;
        for (int i = 0; i < seq.size(); i++) begin
            if (i == abort_cyc) begin
                do_clear();
                return;
            end
            tick();
            if (i == 0) begin IR = ir; CON_FF = con; end
            if (i == stop_cyc) Stop = 1'b1;
            exp_q.push_back(seq[i]);
        end
        halted = seq_halts || Stop;
    endtask

    always @(negedge Clock) begin
        vec_t exp_v, act_v;
        act_v = {Run, alu_op, Cout, Inportout, MDRout, PCout, Zlowout, Zhighout, LOout, HIout,
                 CONin, Outportin, Inportin, MDRin, MARin, IRin, PCin, Zin, Yin, LOin, HIin,
                 BAout, Rout, Rin, Grc, Grb, Gra, IncPC, Write, Read};
        assert ($countones({HIout, LOout, Zhighout, Zlowout, PCout, MDRout, Inportout, Cout,
                            Rout, BAout}) <= 1)
        else begin
            mismatched++;
            $display("FAIL bus_contention t=%0t act=%h", $time, act_v);
        end
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            compared++;
            if (act_v !== exp_v) begin
                mismatched++;
                $display("FAIL ctrl_word t=%0t IR=%h act=%h exp=%h", $time, IR, act_v, exp_v);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit h;
        int stop_c, abort_c;
        logic [4:0] op;
        do_clear();
        run_instr(32'h1A920000, 1'b0, -1, 4, h);
        run_instr(32'h1A920000, 1'b0, -1, -1, h);
        run_instr({5'b00000, 27'h0123456}, 1'b0, -1, -1, h);
        run_instr({5'b00010, 27'h0654321}, 1'b1, -1, -1, h);
        run_instr({5'b10010, 27'h0000042}, 1'b0, -1, -1, h);
        run_instr({5'b10010, 27'h0000042}, 1'b1, -1, -1, h);
        run_instr({5'b01110, 27'h0000777}, 1'b0, 4, -1, h);
        if (h) begin halt_cycles(12); do_clear(); end
        run_instr({5'b11111, 27'h7FFFFFF}, 1'b0, -1, -1, h);
        run_instr({5'b11010, 27'h0000000}, 1'b0, -1, -1, h);
        if (h) begin halt_cycles(10); do_clear(); end
        for (int n = 0; n < 120; n++) begin
            op      = 5'($urandom_range(0, 31));
            stop_c  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7)) : -1;
            abort_c = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1;
            run_instr({op, 27'($urandom)}, 1'($urandom), stop_c, abort_c, h);
            if (h) begin halt_cycles(int'($urandom_range(1, 4))); do_clear(); end
        end
        repeat (3) tick();
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL queue_drain left=%0d required=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit that sits directly upstream of `datapath` and drives every control input that the unit benches currently hand-sequence.
- Runs the fetch and execute step sequence T0..T7 for each instruction, decoding IR[31:27].
- Samples the CON flip-flop for conditional branches.
- Exposes `Run` to the board so a halted CPU is visible.

Parameters:
- `ADD_OP`, 5'b00011, ALU code driven on `alu_op` for address and PC-offset additions.

Ports:
- `Clock`  input  1  system clock; all state changes on the rising edge.
- `clear`  input  1  asynchronous, active-high reset.
- `IR`  input  32  instruction register contents from `datapath`; only [31:27] are decoded.
- `CON_FF`  input  1  branch condition result from `datapath`.
- `Stop`  input  1  request to halt at the next instruction boundary.
- `Run`  output  1  1 while executing, 0 in HALT.
- `alu_op`  output  5  ALU operation select (`opcode` input of `datapath`); 0 when no ALU step is active.
- `Read`, `Write`, `IncPC`  output  1 each  memory and PC-increment strobes.
- `Gra`, `Grb`, `Grc`, `Rin`, `Rout`, `BAout`  output  1 each  register-file select and enable signals.
- `HIin`, `LOin`, `Yin`, `Zin`, `PCin`, `IRin`, `MARin`, `MDRin`, `Inportin`, `Outportin`, `CONin`  output  1 each  register load enables.
- `HIout`, `LOout`, `Zhighout`, `Zlowout`, `PCout`, `MDRout`, `Inportout`, `Cout`  output  1 each  bus drive enables.

Behaviour:
- State register states: RESET, T0..T7, HALT. One state per clock.
- Outputs are combinational from the state register, IR[31:27] and CON_FF.
- Any output not listed for a state is 0.
- Reset:
  - `clear`=1 forces RESET immediately, even mid-instruction; the partial instruction is abandoned.
  - In RESET all strobes are 0, `alu_op`=0 and `Run`=1.
  - The first edge after `clear` falls enters T0.
- Fetch (all instructions):
  - T0: `PCout`, `MARin`, `IncPC`, `Zin`.
  - T1: `Zlowout`, `PCin`, `Read`, `MDRin`.
  - T2: `MDRout`, `IRin`.
  - IR is valid from T3 onward.
- Execute sequences by opcode (after the last listed step, next state is T0):
  - add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010:
    - T3: `Grb` `Rout` `Yin`.
    - T4: `Grc` `Rout` `Zin`, `alu_op`=opcode.
    - T5: `Zlowout` `Gra` `Rin`.
  - addi 01011, andi 01100, ori 01101: as the ALU group, but T4 uses `Cout` in place of `Grc` `Rout`.
  - mul 01110, div 01111:
    - T3: `Gra` `Rout` `Yin`.
    - T4: `Grb` `Rout` `Zin`, `alu_op`=opcode.
    - T5: `Zlowout` `LOin`.
    - T6: `Zhighout` `HIin`.
  - neg 10000, not 10001:
    - T3: `Grb` `Rout` `Zin`, `alu_op`=opcode.
    - T4: `Zlowout` `Gra` `Rin`.
  - ld 00000:
    - T3: `Grb` `BAout` `Yin`.
    - T4: `Cout` `Zin`, `alu_op`=`ADD_OP`.
    - T5: `Zlowout` `MARin`.
    - T6: `Read` `MDRin`.
    - T7: `MDRout` `Gra` `Rin`.
  - ldi 00001: T3 and T4 as ld; T5: `Zlowout` `Gra` `Rin`.
  - st 00010:
    - T3–T5 as ld.
    - T6: `Gra` `Rout` `MDRin` (with `Read`=0).
    - T7: `Write`.
  - br 10010:
    - T3: `Gra` `Rout` `CONin`.
    - T4: `PCout` `Yin`.
    - T5: `Cout` `Zin`, `alu_op`=`ADD_OP`.
    - T6: `Zlowout` and `PCin` only when `CON_FF`=1.
    - The T6 cycle is always spent, even when the branch is not taken.
  - Single-step T3 instructions:
    - jr 10011: `Gra` `Rout` `PCin`.
    - in 10101: `Inportout` `Gra` `Rin`.
    - out 10110: `Gra` `Rout` `Outportin`.
    - mfhi 10111: `HIout` `Gra` `Rin`.
    - mflo 11000: `LOout` `Gra` `Rin`.
  - nop 11001, and any unlisted opcode: T2 -> T0.
  - halt 11010: T2 -> HALT.
- Instruction cycle counts, including fetch:
  - nop: 3.
  - Single-step T3 instructions: 4.
  - neg/not: 5.
  - ALU group, immediates, ldi: 6.
  - mul/div, br: 7.
  - ld, st: 8.
- Stop:
  - Sampled on the edge that would enter T0.
  - If 1, the next state is HALT instead; the current instruction always completes.
- HALT:
  - All strobes are 0, `alu_op`=0, `Run`=0.
  - Exited only by `clear`.
- Bus contention rule: at most one `*out` strobe is high in any state, and a bench assertion checks this every cycle.

Test Plan:
- Assert `clear` during T4 of an add -> all outputs 0 in the same cycle; after release, the first cycle shows `PCout`=`MARin`=`IncPC`=`Zin`=1 and `Run`=1.
- IR=0x1A920000 (add R5,R2,R4) -> T3 `Grb`/`Rout`/`Yin`; T4 `Grc`/`Rout`/`Zin` with `alu_op`=00011; T5 `Zlowout`/`Gra`/`Rin`; T0 again on cycle 7.
- ld (opcode 00000) then st (opcode 00010) -> 8 cycles each; ld has `Read`=1 in T1 and T6; st has `Write`=1 only in T7; `alu_op`=00011 in T4 of both.
- br (opcode 10010) run twice, with `CON_FF`=0 then `CON_FF`=1 -> T6 `PCin`=0 then `PCin`=1; both take 7 cycles.
- halt (opcode 11010) -> `Run`=0 after T2 and all strobes held at 0 for 10 or more cycles; a `clear` pulse restores T0.
- `Stop`=1 raised during T4 of mul -> T5 `LOin` and T6 `HIin` still occur, then HALT; opcode 11111 -> behaves as nop, T0 after T2.
